// File: rtl/mips_mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the unified-memory arbiter.
// The slave modport is the arbiter's view; the master modport is the pipeline/memory view.
interface mips_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Single-ported unified memory arbiter between the fetch (IF) and load/store (D) requesters.
// One access in flight; D has fixed priority, IF is forced through after STARVE_MAX straight D wins.
// Every output is a flop decoded from the next state, so requesters see clean registered pulses.
module mips_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  mips_mem_arbiter_if.slave bus
);

  localparam int LCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [LCW-1:0] LAT_LAST   = LCW'(MEM_LAT - 1);
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [LCW-1:0] lat_cnt_q, lat_cnt_d;
  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
  logic          win_if_q, win_if_d;
  logic          win_we_q, win_we_d;

  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_gnt_q, if_gnt_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic          d_gnt_q, d_gnt_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          busy_q, busy_d;

  logic          pick_if;

  // Next-state, arbitration, read-data capture and registered-output decode
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    win_if_d     = win_if_q;
    win_we_d     = win_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    pick_if      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        pick_if = bus.if_req && (!bus.d_req || (starve_cnt_q == STARVE_LIM));
        if (bus.if_req || bus.d_req) begin
          state_d  = ISSUE;
          win_if_d = pick_if;
          if (pick_if) begin
            win_we_d   = 1'b0;
            mem_addr_d = bus.if_addr;
          end else begin
            win_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end
        end else begin
          state_d = IDLE;
        end
        if (!bus.if_req || pick_if) begin
          starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_LIM) begin
          starve_cnt_d = starve_cnt_q + 1'b1;
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        lat_cnt_d = '0;
      end
      WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d = DONE;
          if (win_if_q) begin
            if_rdata_d = bus.mem_rdata;
          end else if (!win_we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    mem_en_d    = (state_d == ISSUE);
    mem_we_d    = (state_d == ISSUE) && win_we_d;
    if_gnt_d    = (state_d == ISSUE) && win_if_d;
    d_gnt_d     = (state_d == ISSUE) && !win_if_d;
    if_rvalid_d = (state_d == DONE) && win_if_d;
    d_rvalid_d  = (state_d == DONE) && !win_if_d;
    busy_d      = (state_d != IDLE);
  end

  // State register and all output flops; reset drops everything to zero immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      win_if_q     <= 1'b0;
      win_we_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_gnt_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      d_gnt_q      <= 1'b0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      win_if_q     <= win_if_d;
      win_we_q     <= win_we_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_gnt_q     <= if_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_gnt_q      <= d_gnt_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each talking to a small behavioural memory with matching read latency.
module tb_mips_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] mem0 [0:1023];
  logic [31:0] mem1 [0:1023];
  logic [31:0] rd1_p1, rd1_p2, rd1_p3;

  logic [5:0] seq;
  int         ngnt;

  mips_mem_arbiter_if #(.AW(10), .DW(32)) bus0 ();
  mips_mem_arbiter_if #(.AW(10), .DW(32)) bus1 ();

  mips_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mips_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency memory for dut0; preloaded while reset is held across an edge
  always @(posedge clk) begin
    if (rst) begin
      mem0[1] <= 32'h11111111;
      mem0[2] <= 32'h22222222;
      mem0[5] <= 32'hDEADBEEF;
    end else if (bus0.mem_en) begin
      if (bus0.mem_we) mem0[bus0.mem_addr] <= bus0.mem_wdata;
      else             bus0.mem_rdata      <= mem0[bus0.mem_addr];
    end
  end

  // Three-cycle-latency memory for dut1
  always @(posedge clk) begin
    if (rst) begin
      mem1[7] <= 32'h77777777;
    end else if (bus1.mem_en && bus1.mem_we) begin
      mem1[bus1.mem_addr] <= bus1.mem_wdata;
    end else if (bus1.mem_en) begin
      rd1_p1 <= mem1[bus1.mem_addr];
    end
    rd1_p2 <= rd1_p1;
    rd1_p3 <= rd1_p2;
  end
  assign bus1.mem_rdata = rd1_p3;

  // Advance one cycle and land 1 ns after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the requester inputs of the MEM_LAT=1 instance
  task automatic applyStimulus(input logic ifr, input logic [9:0] ifa,
                               input logic dr, input logic dwe,
                               input logic [9:0] da, input logic [31:0] dwd);
    bus0.if_req  = ifr;
    bus0.if_addr = ifa;
    bus0.d_req   = dr;
    bus0.d_we    = dwe;
    bus0.d_addr  = da;
    bus0.d_wdata = dwd;
  endtask

  // Compare one observed value against its expected value and count the outcome
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Directed sequence of all scenarios
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    mem0[5'h10] = 32'h0;
    bus0.mem_rdata = 32'h0;
    rd1_p1 = 32'h0;
    rd1_p2 = 32'h0;
    rd1_p3 = 32'h0;
    applyStimulus(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0);
    bus1.if_req  = 1'b0;
    bus1.if_addr = 10'h0;
    bus1.d_req   = 1'b0;
    bus1.d_we    = 1'b0;
    bus1.d_addr  = 10'h0;
    bus1.d_wdata = 32'h0;

    repeat (3) tick();
    $display("[TB] reset state");
    checkOutput("rst_busy",      {31'h0, bus0.busy},      32'h0);
    checkOutput("rst_mem_en",    {31'h0, bus0.mem_en},    32'h0);
    checkOutput("rst_mem_we",    {31'h0, bus0.mem_we},    32'h0);
    checkOutput("rst_mem_addr",  {22'h0, bus0.mem_addr},  32'h0);
    checkOutput("rst_mem_wdata", bus0.mem_wdata,          32'h0);
    checkOutput("rst_gnts",      {30'h0, bus0.if_gnt, bus0.d_gnt},     32'h0);
    checkOutput("rst_rvalids",   {30'h0, bus0.if_rvalid, bus0.d_rvalid}, 32'h0);
    checkOutput("rst_if_rdata",  bus0.if_rdata,           32'h0);
    checkOutput("rst_d_rdata",   bus0.d_rdata,            32'h0);
    rst = 1'b0;
    tick();

    $display("[TB] single fetch");
    applyStimulus(1'b1, 10'd5, 1'b0, 1'b0, 10'h0, 32'h0);
    tick();
    checkOutput("t1_if_gnt",   {31'h0, bus0.if_gnt},  32'h1);
    checkOutput("t1_mem_en",   {31'h0, bus0.mem_en},  32'h1);
    checkOutput("t1_mem_we",   {31'h0, bus0.mem_we},  32'h0);
    checkOutput("t1_mem_addr", {22'h0, bus0.mem_addr}, 32'd5);
    checkOutput("t1_busy",     {31'h0, bus0.busy},    32'h1);
    applyStimulus(1'b0, 10'd5, 1'b0, 1'b0, 10'h0, 32'h0);
    tick();
    checkOutput("t1_wait_rvalid", {31'h0, bus0.if_rvalid}, 32'h0);
    checkOutput("t1_wait_mem_en", {31'h0, bus0.mem_en},    32'h0);
    tick();
    checkOutput("t1_if_rvalid", {31'h0, bus0.if_rvalid}, 32'h1);
    checkOutput("t1_if_rdata",  bus0.if_rdata,           32'hDEADBEEF);
    tick();
    checkOutput("t1_idle_busy", {31'h0, bus0.busy},      32'h0);
    checkOutput("t1_idle_rv",   {31'h0, bus0.if_rvalid}, 32'h0);

    $display("[TB] simultaneous fetch and load");
    applyStimulus(1'b1, 10'd1, 1'b1, 1'b0, 10'd2, 32'h0);
    tick();
    checkOutput("t2_d_gnt",    {31'h0, bus0.d_gnt},   32'h1);
    checkOutput("t2_if_gnt0",  {31'h0, bus0.if_gnt},  32'h0);
    checkOutput("t2_mem_addr", {22'h0, bus0.mem_addr}, 32'd2);
    applyStimulus(1'b1, 10'd1, 1'b0, 1'b0, 10'd2, 32'h0);
    tick();
    tick();
    checkOutput("t2_d_rvalid", {31'h0, bus0.d_rvalid},  32'h1);
    checkOutput("t2_d_rdata",  bus0.d_rdata,            32'h22222222);
    checkOutput("t2_if_rv0",   {31'h0, bus0.if_rvalid}, 32'h0);
    tick();
    checkOutput("t2_if_gnt",    {31'h0, bus0.if_gnt},   32'h1);
    checkOutput("t2_if_addr",   {22'h0, bus0.mem_addr}, 32'd1);
    applyStimulus(1'b0, 10'd1, 1'b0, 1'b0, 10'd2, 32'h0);
    tick();
    tick();
    checkOutput("t2_if_rvalid", {31'h0, bus0.if_rvalid}, 32'h1);
    checkOutput("t2_if_rdata",  bus0.if_rdata,           32'h11111111);
    checkOutput("t2_d_hold",    bus0.d_rdata,            32'h22222222);
    checkOutput("t2_d_rv_quiet", {31'h0, bus0.d_rvalid}, 32'h0);
    tick();

    $display("[TB] starvation guard");
    seq  = 6'h0;
    ngnt = 0;
    applyStimulus(1'b1, 10'd1, 1'b1, 1'b0, 10'd2, 32'h0);
    for (int i = 0; i < 18; i++) begin
      tick();
      if (bus0.d_gnt || bus0.if_gnt) begin
        if (ngnt < 6) seq[ngnt] = bus0.if_gnt;
        ngnt++;
      end
    end
    applyStimulus(1'b0, 10'd1, 1'b0, 1'b0, 10'd2, 32'h0);
    checkOutput("t3_num_gnts", ngnt,         32'd6);
    checkOutput("t3_gnt_order", {26'h0, seq}, 32'h10);
    tick();
    tick();
    checkOutput("t3_idle_busy", {31'h0, bus0.busy}, 32'h0);

    $display("[TB] store then load back");
    applyStimulus(1'b0, 10'h0, 1'b1, 1'b1, 10'h010, 32'h00001234);
    tick();
    checkOutput("t4_d_gnt",     {31'h0, bus0.d_gnt},    32'h1);
    checkOutput("t4_mem_we",    {31'h0, bus0.mem_we},   32'h1);
    checkOutput("t4_mem_addr",  {22'h0, bus0.mem_addr}, 32'h010);
    checkOutput("t4_mem_wdata", bus0.mem_wdata,         32'h00001234);
    applyStimulus(1'b0, 10'h0, 1'b0, 1'b0, 10'h010, 32'h0);
    tick();
    checkOutput("t4_we_drop",   {31'h0, bus0.mem_we},   32'h0);
    checkOutput("t4_en_drop",   {31'h0, bus0.mem_en},   32'h0);
    tick();
    checkOutput("t4_st_rvalid", {31'h0, bus0.d_rvalid}, 32'h1);
    checkOutput("t4_st_rdata",  bus0.d_rdata,           32'h22222222);
    tick();
    checkOutput("t4_hold_addr", {22'h0, bus0.mem_addr}, 32'h010);
    applyStimulus(1'b0, 10'h0, 1'b1, 1'b0, 10'h010, 32'h0);
    tick();
    checkOutput("t4_ld_we",     {31'h0, bus0.mem_we},   32'h0);
    applyStimulus(1'b0, 10'h0, 1'b0, 1'b0, 10'h010, 32'h0);
    tick();
    tick();
    checkOutput("t4_ld_rvalid", {31'h0, bus0.d_rvalid}, 32'h1);
    checkOutput("t4_ld_rdata",  bus0.d_rdata,           32'h00001234);
    tick();

    $display("[TB] reset during load wait");
    applyStimulus(1'b0, 10'h0, 1'b1, 1'b0, 10'd5, 32'h0);
    tick();
    applyStimulus(1'b0, 10'h0, 1'b0, 1'b0, 10'd5, 32'h0);
    tick();
    checkOutput("t5_in_wait", {31'h0, bus0.busy}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("t5_busy",     {31'h0, bus0.busy},     32'h0);
    checkOutput("t5_d_rdata",  bus0.d_rdata,           32'h0);
    checkOutput("t5_if_rdata", bus0.if_rdata,          32'h0);
    checkOutput("t5_mem_addr", {22'h0, bus0.mem_addr}, 32'h0);
    checkOutput("t5_mem_wd",   bus0.mem_wdata,         32'h0);
    rst = 1'b0;
    tick();
    checkOutput("t5_no_rvalid", {31'h0, bus0.d_rvalid}, 32'h0);
    tick();
    checkOutput("t5_no_rvalid2", {31'h0, bus0.d_rvalid}, 32'h0);
    applyStimulus(1'b1, 10'd5, 1'b0, 1'b0, 10'h0, 32'h0);
    tick();
    checkOutput("t5_if_gnt", {31'h0, bus0.if_gnt}, 32'h1);
    applyStimulus(1'b0, 10'd5, 1'b0, 1'b0, 10'h0, 32'h0);
    tick();
    tick();
    checkOutput("t5_if_rvalid", {31'h0, bus0.if_rvalid}, 32'h1);
    checkOutput("t5_if_rdata",  bus0.if_rdata,           32'hDEADBEEF);
    tick();

    $display("[TB] three-cycle memory latency");
    bus1.d_req  = 1'b1;
    bus1.d_we   = 1'b0;
    bus1.d_addr = 10'd7;
    tick();
    checkOutput("t6_d_gnt", {31'h0, bus1.d_gnt}, 32'h1);
    checkOutput("t6_busy1", {31'h0, bus1.busy},  32'h1);
    bus1.d_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t6_wait_busy", {31'h0, bus1.busy},     32'h1);
      checkOutput("t6_wait_rv",   {31'h0, bus1.d_rvalid}, 32'h0);
    end
    tick();
    checkOutput("t6_d_rvalid", {31'h0, bus1.d_rvalid}, 32'h1);
    checkOutput("t6_d_rdata",  bus1.d_rdata,           32'h77777777);
    checkOutput("t6_busy5",    {31'h0, bus1.busy},     32'h1);
    tick();
    checkOutput("t6_idle_busy", {31'h0, bus1.busy},     32'h0);
    checkOutput("t6_idle_rv",   {31'h0, bus1.d_rvalid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
